// File: rtl/axi_mem_pkg.sv
// axi_mem_pkg: FSM state types and response codes shared by the AXI-lite memory slave
package axi_mem_pkg;
  typedef enum logic [1:0] {OKAY = 2'b00, SLVERR = 2'b10} resp_t;
  typedef enum logic {WR_COLLECT, WR_RESP} wr_state_t;
  typedef enum logic [1:0] {RD_IDLE, RD_WAIT, RD_DATA} rd_state_t;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
endpackage

// File: rtl/axi_mem_array.sv
// axi_mem_array: DEPTH x DATA_W storage, byte-enabled sync write port, registered read port
module axi_mem_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH = 128,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                we,
  input  logic [IDX_W-1:0]    wa,
  input  logic [DATA_W-1:0]   wd,
  input  logic [DATA_W/8-1:0] ws,
  input  logic                re,
  input  logic                rd_clr,
  input  logic [IDX_W-1:0]    ra,
  output logic [DATA_W-1:0]   rd
);
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we)
      for (int b = 0; b < DATA_W / 8; b++)
        if (ws[b]) mem[wa][b*8 +: 8] <= wd[b*8 +: 8];
  end
  // Read samples pre-write contents, so a same-edge write to the same word returns old data
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rd <= '0;
    else if (re) rd <= rd_clr ? '0 : mem[ra];
  end
endmodule

// File: rtl/axi_lite_mem_slave.sv
// axi_lite_mem_slave: AXI-lite word-addressed memory slave with read wait states.
// Define AXI_MEM_RANGE_CHECK_EN to answer SLVERR for addr >= DEPTH; otherwise addresses alias modulo DEPTH.
module axi_lite_mem_slave
  import axi_mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 7,
  parameter int DEPTH = 128,
  parameter int WAIT_CYC = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   aw_addr,
  input  logic                aw_valid,
  output logic                aw_ready,
  input  logic [DATA_W-1:0]   w_data,
  input  logic [DATA_W/8-1:0] w_strb,
  input  logic                w_valid,
  output logic                w_ready,
  output logic                b_valid,
  input  logic                b_ready,
  output logic [1:0]          b_resp,
  input  logic [ADDR_W-1:0]   ar_addr,
  input  logic                ar_valid,
  output logic                ar_ready,
  output logic [DATA_W-1:0]   r_data,
  output logic [1:0]          r_resp,
  output logic                r_valid,
  input  logic                r_ready
);
  localparam int STRB_W = DATA_W / 8;
  localparam int IDX_W = $clog2(DEPTH);
  wr_state_t wr_st, wr_nx;
  rd_state_t rd_st, rd_nx;
  logic aw_held, w_held, aw_held_nx, w_held_nx, aw_hs, w_hs, ar_hs, b_hs, r_hs;
  logic commit, rd_load, oor_w, oor_r;
  logic [ADDR_W-1:0] aw_addr_q, ar_addr_q, wa, ra;
  logic [DATA_W-1:0] w_data_q, wd;
  logic [STRB_W-1:0] w_strb_q, ws;
  logic [3:0] cnt;
  assign b_valid = wr_st == WR_RESP;
  assign r_valid = rd_st == RD_DATA;
  always_comb begin
    aw_hs = aw_valid && aw_ready;
    w_hs = w_valid && w_ready;
    ar_hs = ar_valid && ar_ready;
    b_hs = b_valid && b_ready;
    r_hs = r_valid && r_ready;
    commit = wr_st == WR_COLLECT && (aw_held || aw_hs) && (w_held || w_hs);
    aw_held_nx = (aw_held || aw_hs) && !b_hs;
    w_held_nx = (w_held || w_hs) && !b_hs;
    wr_nx = commit ? WR_RESP : b_hs ? WR_COLLECT : wr_st;
    wa = aw_held ? aw_addr_q : aw_addr;
    wd = w_held ? w_data_q : w_data;
    ws = w_held ? w_strb_q : w_strb;
    ra = rd_st == RD_IDLE ? ar_addr : ar_addr_q;
    rd_load = (ar_hs && WAIT_CYC == 0) || (rd_st == RD_WAIT && cnt == 4'd1);
    rd_nx = rd_load ? RD_DATA : ar_hs ? RD_WAIT : r_hs ? RD_IDLE : rd_st;
  end
`ifdef AXI_MEM_RANGE_CHECK_EN
  localparam logic [ADDR_W:0] LIM = DEPTH[ADDR_W:0];
  assign oor_w = {1'b0, wa} >= LIM;
  assign oor_r = {1'b0, ra} >= LIM;
`else
  assign oor_w = 1'b0;
  assign oor_r = 1'b0;
`endif
  // Readies are registered from next-state so they stay low through reset and rise one edge after release
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_st <= WR_COLLECT;
      rd_st <= RD_IDLE;
      aw_held <= 1'b0;
      w_held <= 1'b0;
      aw_ready <= 1'b0;
      w_ready <= 1'b0;
      ar_ready <= 1'b0;
      b_resp <= RESP_OKAY;
      r_resp <= RESP_OKAY;
      cnt <= '0;
      aw_addr_q <= '0;
      ar_addr_q <= '0;
      w_data_q <= '0;
      w_strb_q <= '0;
    end else begin
      wr_st <= wr_nx;
      rd_st <= rd_nx;
      aw_held <= aw_held_nx;
      w_held <= w_held_nx;
      aw_ready <= wr_nx == WR_COLLECT && !aw_held_nx;
      w_ready <= wr_nx == WR_COLLECT && !w_held_nx;
      ar_ready <= rd_nx == RD_IDLE;
      if (aw_hs) aw_addr_q <= aw_addr;
      if (w_hs) begin
        w_data_q <= w_data;
        w_strb_q <= w_strb;
      end
      if (ar_hs) ar_addr_q <= ar_addr;
      if (commit) b_resp <= oor_w ? RESP_SLVERR : RESP_OKAY;
      if (rd_load) r_resp <= oor_r ? RESP_SLVERR : RESP_OKAY;
      cnt <= ar_hs ? 4'(WAIT_CYC) : rd_st == RD_WAIT ? cnt - 4'd1 : cnt;
    end
  end
  axi_mem_array #(.DATA_W(DATA_W), .DEPTH(DEPTH), .IDX_W(IDX_W)) u_mem (
    .clk(clk),
    .reset(reset),
    .we(commit && !oor_w),
    .wa(wa[IDX_W-1:0]),
    .wd(wd),
    .ws(ws),
    .re(rd_load),
    .rd_clr(oor_r),
    .ra(ra[IDX_W-1:0]),
    .rd(r_data)
  );
endmodule

// File: tb/tb_axi_lite_mem_slave.sv
// tb_axi_lite_mem_slave: directed table, corner sequences and random traffic against an array model
module tb_axi_lite_mem_slave;
  import axi_mem_pkg::*;
`ifdef AXI_MEM_RANGE_CHECK_EN
  localparam int AW = 7;
  localparam int DEP = 100;
`else
  localparam int AW = 8;
  localparam int DEP = 128;
`endif
  localparam int WC = 2;

  logic clk = 1'b0, reset = 1'b0;
  logic [AW-1:0] aw_addr, ar_addr;
  logic aw_valid, aw_ready, w_valid, w_ready, b_valid, b_ready, ar_valid, ar_ready, r_valid, r_ready;
  logic [31:0] w_data, r_data;
  logic [3:0] w_strb;
  logic [1:0] b_resp, r_resp;
  int checks = 0, errors = 0;
  logic [31:0] model [DEP];

  always #5 clk = ~clk;

  axi_lite_mem_slave #(.DATA_W(32), .ADDR_W(AW), .DEPTH(DEP), .WAIT_CYC(WC)) dut (
    .clk(clk), .reset(reset),
    .aw_addr(aw_addr), .aw_valid(aw_valid), .aw_ready(aw_ready),
    .w_data(w_data), .w_strb(w_strb), .w_valid(w_valid), .w_ready(w_ready),
    .b_valid(b_valid), .b_ready(b_ready), .b_resp(b_resp),
    .ar_addr(ar_addr), .ar_valid(ar_valid), .ar_ready(ar_ready),
    .r_data(r_data), .r_resp(r_resp), .r_valid(r_valid), .r_ready(r_ready)
  );

  typedef struct {
    int wa; logic [31:0] d; logic [3:0] s; int lead; int bh; logic [1:0] eb;
    int ra; logic [31:0] er; logic [1:0] err;
  } vec_t;
  vec_t tab [8];

  function automatic bit oor(input int a);
`ifdef AXI_MEM_RANGE_CHECK_EN
    return a >= DEP;
`else
    return 1'b0;
`endif
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // lead > 0: W leads AW by lead cycles; lead < 0: AW leads W
  task automatic do_write(input int a, input logic [31:0] d, input logic [3:0] s,
                          input int lead, input int bhold, input logic [1:0] eb);
    bit ad = 0, wd = 0;
    int t = 0;
    aw_addr = a[AW-1:0];
    w_data = d;
    w_strb = s;
    while (!(ad && wd) && t < 60) begin
      aw_valid = !ad && t >= (lead > 0 ? lead : 0);
      w_valid = !wd && t >= (lead < 0 ? -lead : 0);
      if (aw_valid && aw_ready) ad = 1;
      if (w_valid && w_ready) wd = 1;
      @(posedge clk);
      @(negedge clk);
      aw_valid = 0;
      w_valid = 0;
      if (wd && !ad) begin check("w_ready_low", w_ready, 0); check("b_early", b_valid, 0); end
      if (ad && !wd) begin check("aw_ready_low", aw_ready, 0); check("b_early", b_valid, 0); end
      t++;
    end
    check("wr_handshakes", ad && wd, 1);
    check("b_latency", b_valid, 1);
    check("b_resp", b_resp, eb);
    repeat (bhold) begin
      @(negedge clk);
      check("b_hold_valid", b_valid, 1);
      check("b_hold_resp", b_resp, eb);
    end
    b_ready = 1;
    @(posedge clk);
    @(negedge clk);
    b_ready = 0;
    check("b_done", b_valid, 0);
    check("wr_readies_back", {aw_ready, w_ready}, 2'b11);
    if (!oor(a))
      for (int b = 0; b < 4; b++)
        if (s[b]) model[a % DEP][b*8 +: 8] = d[b*8 +: 8];
  endtask

  task automatic do_read(input int a, input logic [31:0] ed, input logic [1:0] er);
    int t = 0, lat = 0;
    ar_addr = a[AW-1:0];
    ar_valid = 1;
    while (!ar_ready && t < 20) begin @(negedge clk); t++; end
    check("ar_ready", ar_ready, 1);
    @(posedge clk);
    @(negedge clk);
    ar_valid = 0;
    while (!r_valid && lat < 40) begin @(negedge clk); lat++; end
    check("r_latency", lat, WC);
    check("r_data", r_data, ed);
    check("r_resp", r_resp, er);
    r_ready = 1;
    @(posedge clk);
    @(negedge clk);
    r_ready = 0;
    check("r_done", r_valid, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] old;
    int a;
    {aw_valid, w_valid, b_ready, ar_valid, r_ready} = '0;
    aw_addr = '0; ar_addr = '0; w_data = '0; w_strb = '0;
    repeat (2) @(negedge clk);
    check("rst_flags", {aw_ready, w_ready, ar_ready, b_valid, r_valid}, 5'b0);
    check("rst_data", {r_data, r_resp, b_resp}, 0);
    reset = 1;
    #1 check("ready_before_edge", ar_ready, 0);
    @(negedge clk);
    check("ready_after_edge", {aw_ready, w_ready, ar_ready}, 3'b111);

    for (int i = 0; i < DEP; i++) do_write(i, $urandom, 4'hF, 0, 0, RESP_OKAY);

    tab[0] = '{5, 32'hDEADBEEF, 4'hF, 0, 0, RESP_OKAY, 5, 32'hDEADBEEF, RESP_OKAY};
    tab[1] = '{5, 32'h11223344, 4'b0101, 0, 0, RESP_OKAY, 5, 32'hDE22BE44, RESP_OKAY};
    tab[2] = '{6, 32'hCAFEF00D, 4'hF, 3, 4, RESP_OKAY, 6, 32'hCAFEF00D, RESP_OKAY};
    tab[3] = '{5, 32'hAABBCCDD, 4'b1010, -2, 1, RESP_OKAY, 5, 32'hAA22CC44, RESP_OKAY};
    tab[4] = '{DEP - 1, 32'h12345678, 4'hF, 1, 0, RESP_OKAY, DEP - 1, 32'h12345678, RESP_OKAY};
    tab[5] = '{0, 32'hFFFFFFFF, 4'hF, 0, 0, RESP_OKAY, 0, 32'hFFFFFFFF, RESP_OKAY};
    tab[6] = '{0, 32'h00000000, 4'h0, 0, 0, RESP_OKAY, 0, 32'hFFFFFFFF, RESP_OKAY};
`ifdef AXI_MEM_RANGE_CHECK_EN
    tab[7] = '{120, 32'h55AA55AA, 4'hF, 0, 0, RESP_SLVERR, 120, 32'h0, RESP_SLVERR};
`else
    tab[7] = '{8'h85, 32'h5A5A1234, 4'hF, 0, 0, RESP_OKAY, 8'h05, 32'h5A5A1234, RESP_OKAY};
`endif
    foreach (tab[i]) begin
      do_write(tab[i].wa, tab[i].d, tab[i].s, tab[i].lead, tab[i].bh, tab[i].eb);
      do_read(tab[i].ra, tab[i].er, tab[i].err);
    end

    // Read load and write commit land on the same edge for word 9
    old = model[9];
    ar_addr = 9;
    ar_valid = 1;
    check("col_ar_ready", ar_ready, 1);
    @(posedge clk);
    @(negedge clk);
    ar_valid = 0;
    @(posedge clk);
    @(negedge clk);
    aw_addr = 9; w_data = ~old; w_strb = 4'hF; aw_valid = 1; w_valid = 1;
    check("col_wr_ready", {aw_ready, w_ready}, 2'b11);
    @(posedge clk);
    @(negedge clk);
    aw_valid = 0; w_valid = 0;
    check("col_r_valid", r_valid, 1);
    check("col_old_data", r_data, old);
    check("col_b_valid", b_valid, 1);
    r_ready = 1; b_ready = 1;
    @(posedge clk);
    @(negedge clk);
    r_ready = 0; b_ready = 0;
    model[9] = ~old;
    do_read(9, ~old, RESP_OKAY);

    for (int n = 0; n < 200; n++) begin
      a = int'($urandom_range(0, 2 ** AW - 1));
      if ($urandom_range(0, 1) == 1)
        do_write(a, $urandom, 4'($urandom_range(0, 15)), int'($urandom_range(0, 6)) - 3,
                 int'($urandom_range(0, 2)), oor(a) ? RESP_SLVERR : RESP_OKAY);
      else
        do_read(a, oor(a) ? 32'h0 : model[a % DEP], oor(a) ? RESP_SLVERR : RESP_OKAY);
    end

    // Reset while both a read and a write response are pending
    ar_addr = 3; ar_valid = 1;
    aw_addr = 3; w_data = 32'h0BADF00D; w_strb = 4'hF; aw_valid = 1; w_valid = 1;
    @(posedge clk);
    @(negedge clk);
    ar_valid = 0; aw_valid = 0; w_valid = 0;
    repeat (WC) @(negedge clk);
    check("pre_rst_r_valid", r_valid, 1);
    check("pre_rst_b_valid", b_valid, 1);
    #2 reset = 0;
    #1 check("rst_async_flags", {aw_ready, w_ready, ar_ready, b_valid, r_valid}, 5'b0);
    check("rst_async_data", {r_data, r_resp, b_resp}, 0);
    @(negedge clk);
    reset = 1;
    #1 check("rel_ready_low", ar_ready, 0);
    @(negedge clk);
    check("rel_ready_high", {aw_ready, w_ready, ar_ready}, 3'b111);
    model[3] = 32'h0BADF00D;
    do_read(3, 32'h0BADF00D, RESP_OKAY);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
